// File: rtl/bim_ctr_update_ctrl.sv
// Bimodal counter table controller: init sweep, read-port sharing,
// update read-modify-write with single-cycle write forwarding.
module bim_ctr_update_ctrl #(
  parameter int unsigned ENTRIES  = 512,
  parameter int unsigned LANES    = 8,
  parameter logic [1:0]  INIT_CTR = 2'b01,
  localparam int unsigned IW = $clog2(ENTRIES),
  localparam int unsigned DW = 2 * LANES,
  localparam int unsigned LW = $clog2(LANES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rd_valid,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_resp_valid,
  output logic [DW-1:0] rd_resp_data,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  logic [IW-1:0] upd_idx,
  input  logic [LW-1:0] upd_lane,
  input  logic          upd_taken,
  output logic          init_done,
  output logic          sram_r_en,
  output logic [IW-1:0] sram_r_addr,
  input  logic [DW-1:0] sram_r_data,
  output logic          sram_w_en,
  output logic [IW-1:0] sram_w_addr,
  output logic [DW-1:0] sram_w_data,
  output logic [LANES-1:0] sram_w_mask
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          done_q, done_d;

  logic          resp_v_q, resp_v_d;
  logic [IW-1:0] resp_idx_q, resp_idx_d;

  logic          s1_v_q, s1_v_d;
  logic [IW-1:0] s1_idx_q, s1_idx_d;
  logic [LW-1:0] s1_lane_q, s1_lane_d;
  logic          s1_tkn_q, s1_tkn_d;

  logic          fwd_v_q, fwd_v_d;
  logic [IW-1:0] fwd_idx_q, fwd_idx_d;
  logic [LW-1:0] fwd_lane_q, fwd_lane_d;
  logic [1:0]    fwd_ctr_q, fwd_ctr_d;

  logic          rd_acc, upd_acc, wr_s1;
  logic [1:0]    old_ctr, new_ctr;
  logic [DW-1:0] merged;

  // Init sweep sequencing and the registered init-complete flag
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == IW'(ENTRIES - 1))
        state_d = S_RUN;
    end
    done_d = (state_d == S_RUN);
  end

  // Read-port arbitration: lookups win, updates take idle slots
  always_comb begin
    init_done   = done_q && !reset;
    upd_ready   = init_done && !rd_valid;
    rd_acc      = init_done && rd_valid;
    upd_acc     = upd_valid && upd_ready;
    sram_r_en   = rd_acc || upd_acc;
    sram_r_addr = rd_valid ? rd_idx : upd_idx;
    resp_v_d    = rd_acc;
    resp_idx_d  = rd_idx;
    s1_v_d      = upd_acc;
    s1_idx_d    = upd_idx;
    s1_lane_d   = upd_lane;
    s1_tkn_d    = upd_taken;
  end

  // S1: pick the counter (forwarded if just written) and saturate
  always_comb begin
    old_ctr = sram_r_data[{s1_lane_q, 1'b0} +: 2];
    if (fwd_v_q && fwd_idx_q == s1_idx_q && fwd_lane_q == s1_lane_q)
      old_ctr = fwd_ctr_q;
    if (s1_tkn_q)
      new_ctr = (old_ctr == 2'd3) ? 2'd3 : old_ctr + 2'd1;
    else
      new_ctr = (old_ctr == 2'd0) ? 2'd0 : old_ctr - 2'd1;
    wr_s1      = s1_v_q && !reset;
    fwd_v_d    = wr_s1;
    fwd_idx_d  = s1_idx_q;
    fwd_lane_d = s1_lane_q;
    fwd_ctr_d  = new_ctr;
  end

  // Lookup response with the previous cycle's write merged in
  always_comb begin
    merged = sram_r_data;
    if (fwd_v_q && fwd_idx_q == resp_idx_q)
      merged[{fwd_lane_q, 1'b0} +: 2] = fwd_ctr_q;
    rd_resp_valid = resp_v_q && !reset;
    rd_resp_data  = merged;
  end

  // Write port: init sweep fills whole entries, S1 writes one lane
  always_comb begin
    sram_w_en   = 1'b0;
    sram_w_addr = s1_idx_q;
    sram_w_data = {LANES{new_ctr}};
    sram_w_mask = LANES'(1) << s1_lane_q;
    if (state_q == S_INIT) begin
      sram_w_en   = !reset;
      sram_w_addr = ptr_q;
      sram_w_data = {LANES{INIT_CTR}};
      sram_w_mask = '1;
    end else begin
      sram_w_en = wr_s1;
    end
  end

  // State, pipeline and forwarding registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_INIT;
      ptr_q    <= '0;
      done_q   <= 1'b0;
      resp_v_q <= 1'b0;
      s1_v_q   <= 1'b0;
      fwd_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      resp_v_q <= resp_v_d;
      s1_v_q   <= s1_v_d;
      fwd_v_q  <= fwd_v_d;
    end
    resp_idx_q <= resp_idx_d;
    s1_idx_q   <= s1_idx_d;
    s1_lane_q  <= s1_lane_d;
    s1_tkn_q   <= s1_tkn_d;
    fwd_idx_q  <= fwd_idx_d;
    fwd_lane_q <= fwd_lane_d;
    fwd_ctr_q  <= fwd_ctr_d;
  end

endmodule
